// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding, the iteration limit and small sign helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package muldiv_pkg;

    // Operation select encodings
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Counter value of the final (32nd) iteration
    localparam logic [5:0] MD_LAST_ITER = 6'd31;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_e;

    // Magnitude of a 32-bit value when treated as signed, raw value otherwise
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            md_abs = ~v + 32'd1;
        end else begin
            md_abs = v;
        end
    endfunction

    // Conditional two's-complement negation, 32 bits
    function automatic logic [31:0] md_neg32(input logic [31:0] v, input logic neg);
        if (neg) begin
            md_neg32 = ~v + 32'd1;
        end else begin
            md_neg32 = v;
        end
    endfunction

    // Conditional two's-complement negation, 64 bits
    function automatic logic [63:0] md_neg64(input logic [63:0] v, input logic neg);
        if (neg) begin
            md_neg64 = ~v + 64'd1;
        end else begin
            md_neg64 = v;
        end
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One iteration per clock: shift-add multiply, restoring divide. Signed
// operations work on magnitudes and apply sign correction in a final FIX
// cycle, so HI/LO only ever see complete results.
//
// Ports
//   CLK    in   1   clock, rising edge
//   RST    in   1   asynchronous reset, active low
//   start  in   1   begin operation (accepted only in IDLE)
//   op     in   2   MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   rs     in   32  multiplicand / dividend, also the mthi/mtlo data
//   rt     in   32  multiplier / divisor
//   mthi   in   1   write rs into HI (IDLE without start, or DONE)
//   mtlo   in   1   write rs into LO (IDLE without start, or DONE)
//   busy   out  1   operation in progress (RUN/FIX)
//   done   out  1   one-cycle pulse: HI/LO just written by an operation
//   HI     out  32  product high word / remainder
//   LO     out  32  product low word / quotient
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state_r;
    md_state_e   state_next_s;
    logic [1:0]  op_r;
    logic [31:0] mcand_r;      // multiplicand or divisor magnitude
    logic [31:0] acc_hi_r;     // partial product high / partial remainder
    logic [31:0] acc_lo_r;     // multiplier bits / dividend bits then quotient
    logic [5:0]  cnt_r;
    logic        neg_q_r;      // negate product or quotient
    logic        neg_r_r;      // negate remainder (follows sign of rs)
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic        start_ok_s;
    logic        move_ok_s;
    logic        in_signed_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_trial_s;
    logic        div_ge_s;
    logic [31:0] acc_hi_next_s;
    logic [31:0] acc_lo_next_s;
    logic [63:0] prod_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    assign in_signed_s = ~op[0];

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus start/move acceptance
    always_comb begin
        state_next_s = state_r;
        start_ok_s   = 1'b0;
        move_ok_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                    start_ok_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                    move_ok_s    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_r == MD_LAST_ITER) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX: begin
                state_next_s = DONE;
            end
            DONE: begin
                // Moves are allowed here; start is not, giving the 35-cycle spacing
                state_next_s = IDLE;
                move_ok_s    = 1'b1;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // One multiply or divide iteration on the accumulators
    always_comb begin
        mul_sum_s     = 33'd0;
        div_trial_s   = 33'd0;
        div_ge_s      = 1'b0;
        acc_hi_next_s = acc_hi_r;
        acc_lo_next_s = acc_lo_r;
        if (!op_r[1]) begin
            // Shift-add: add multiplicand when the current multiplier bit is set,
            // then shift {carry, hi, lo} right by one.
            if (acc_lo_r[0]) begin
                mul_sum_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
            end else begin
                mul_sum_s = {1'b0, acc_hi_r};
            end
            acc_hi_next_s = mul_sum_s[32:1];
            acc_lo_next_s = {mul_sum_s[0], acc_lo_r[31:1]};
        end else begin
            // Restoring divide: shift in next dividend bit, subtract if it fits.
            // A zero divisor always "fits", yielding all-ones quotient and rem = dividend.
            div_trial_s = {acc_hi_r, acc_lo_r[31]};
            div_ge_s    = (div_trial_s >= {1'b0, mcand_r});
            if (div_ge_s) begin
                acc_hi_next_s = div_trial_s[31:0] - mcand_r;
                acc_lo_next_s = {acc_lo_r[30:0], 1'b1};
            end else begin
                acc_hi_next_s = div_trial_s[31:0];
                acc_lo_next_s = {acc_lo_r[30:0], 1'b0};
            end
        end
    end

    // Sign correction of the final accumulator contents
    always_comb begin
        prod_s   = 64'd0;
        fix_hi_s = acc_hi_r;
        fix_lo_s = acc_lo_r;
        if (!op_r[1]) begin
            prod_s   = md_neg64({acc_hi_r, acc_lo_r}, neg_q_r);
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end else begin
            // Remainder of a divide-by-zero is |rs|; negating by the sign of rs restores rs
            fix_hi_s = md_neg32(acc_hi_r, neg_r_r);
            if (div_zero_r) begin
                fix_lo_s = 32'hFFFF_FFFF;
            end else begin
                fix_lo_s = md_neg32(acc_lo_r, neg_q_r);
            end
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_r       <= MD_MULT;
            mcand_r    <= 32'd0;
            acc_hi_r   <= 32'd0;
            acc_lo_r   <= 32'd0;
            cnt_r      <= 6'd0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (start_ok_s) begin
            op_r       <= op;
            acc_hi_r   <= 32'd0;
            cnt_r      <= 6'd0;
            neg_q_r    <= in_signed_s & (rs[31] ^ rt[31]);
            neg_r_r    <= in_signed_s & rs[31];
            div_zero_r <= op[1] & (rt == 32'd0);
            if (op[1]) begin
                mcand_r  <= md_abs(rt, in_signed_s);
                acc_lo_r <= md_abs(rs, in_signed_s);
            end else begin
                mcand_r  <= md_abs(rs, in_signed_s);
                acc_lo_r <= md_abs(rt, in_signed_s);
            end
        end else if (state_r == RUN) begin
            acc_hi_r <= acc_hi_next_s;
            acc_lo_r <= acc_lo_next_s;
            cnt_r    <= cnt_r + 6'd1;
        end
    end

    // Architectural HI/LO and status outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (state_r == FIX) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else if (move_ok_s) begin
                if (mthi) begin
                    hi_r <= rs;
                end
                if (mtlo) begin
                    lo_r <= rs;
                end
            end
            busy_r <= (state_next_s == RUN) || (state_next_s == FIX);
            done_r <= (state_next_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit. Inputs change and outputs
// are sampled on the falling clock edge; expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit dut (
        .CLK   (clk),
        .RST   (rst_n),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .HI    (hi),
        .LO    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one operation; returns with the unit in DONE (done visible).
    // inj >= 0 injects start(DIV)+mthi(rs=1234) for one cycle at that offset.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int inj);
        int k;
        logic [31:0] hi0;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        hi0 = hi;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && k < 40) begin
            if (k == inj) begin
                start = 1'b1; op = MD_DIV; mthi = 1'b1; rs = 32'h0000_1234;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            @(negedge clk);
            k++;
            if (k == 16) check_val({tag, "_hold"}, hi, hi0);
        end
        start = 1'b0; mthi = 1'b0;
        check_val({tag, "_lat"}, k, 32'd33);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
    endtask

    // Step out of DONE and confirm the pulse ended
    task automatic finish_op(input string tag);
        @(negedge clk);
        check_val({tag, "_done0"}, {31'd0, done}, 32'd0);
        check_val({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    endtask

    // Single mthi/mtlo move from IDLE
    task automatic do_move(input string tag, input logic h, input logic l,
                           input logic [31:0] v, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        @(negedge clk);
        mthi = h; mtlo = l; rs = v;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; op = MD_MULT; rs = 32'd0; rt = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_hi",   hi, 32'd0);
        check_val("rst_lo",   lo, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        do_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);
        finish_op("mult_neg");
        do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
        finish_op("multu_max");
        do_op("mult_minmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
        finish_op("mult_minmin");
        do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
        finish_op("div_neg");
        do_op("divu_zero", MD_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, -1);
        finish_op("divu_zero");
        do_op("div_zero", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
        finish_op("div_zero");
        do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
        finish_op("div_ovf");
        do_op("div_negdiv", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1);
        finish_op("div_negdiv");

        // Moves from IDLE
        do_move("mthi", 1'b1, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555, 32'hFFFF_FFFD);
        do_move("mtlo", 1'b0, 1'b1, 32'h1357_9BDF, 32'hAAAA_5555, 32'h1357_9BDF);
        do_move("mtboth", 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0005);

        // start and mthi together in IDLE: start wins, move dropped
        @(negedge clk);
        start = 1'b1; mthi = 1'b1; op = MD_MULTU; rs = 32'h0000_0009; rt = 32'h0000_0002;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check_val("startwin_hi", hi, 32'h0000_0005);
        check_val("startwin_busy", {31'd0, busy}, 32'd1);
        repeat (33) @(negedge clk);
        check_val("startwin_lo", lo, 32'h0000_0012);
        check_val("startwin_done", {31'd0, done}, 32'd1);

        // In DONE: mthi accepted, start ignored
        start = 1'b1; mthi = 1'b1; op = MD_MULTU; rs = 32'h0000_0055; rt = 32'h0000_0003;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        check_val("indone_hi", hi, 32'h0000_0055);
        check_val("indone_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("indone_busy2", {31'd0, busy}, 32'd0);

        // start(DIV)+mthi injected while busy are ignored
        do_op("multu_inj", MD_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 10);
        finish_op("multu_inj");
        check_val("inj_idle_hi", hi, 32'h0000_0000);

        do_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, -1);
        finish_op("divu_100_7");

        // Reset mid-operation, away from any clock edge
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_hi", hi, 32'd0);
        check_val("midrst_lo", lo, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check_val("midrst_quiet", seen, 32'd0);
        check_val("midrst_hi2", hi, 32'd0);

        // First operation after reset keeps normal latency
        do_op("post_rst", MD_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, -1);
        finish_op("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
